// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and its ALU decoder.
// Select/control encodings match the datapath mux wiring in the multicycle CPU top.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        JAL,
        BEQ,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_IALU  = 7'd19;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps ALUOp and instruction function fields to an ALU operation.
// illegal flags an unsupported funct3 independent of ALUOp so DECODE can test it early.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_bit5,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    logic [2:0] funct_ctl;

    always_comb begin
        funct_ctl = ALU_ADD;
        illegal   = 1'b0;
        case (funct3)
            3'b000:  funct_ctl = (op5 && funct7_bit5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl = ALU_SLT;
            3'b110:  funct_ctl = ALU_OR;
            3'b111:  funct_ctl = ALU_AND;
            default: illegal   = 1'b1;
        endcase
    end

    always_comb begin
        case (ALUOp)
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_ctl;
            default:     ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: state register plus combinational next-state and
// control outputs for fetch/decode/execute/memory/writeback over a shared memory port.
module multicycle_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_bit5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       InstrDone,
    output logic       Trap
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       funct_illegal;

    alu_decoder u_alu_decoder (
        .ALUOp       (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_bit5 (funct7_bit5),
        .ALUControl  (ALUControl),
        .illegal     (funct_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Kept apart from the main decode block so the decoder is not in a feedback path.
    always_comb begin
        alu_op = ALUOP_ADD;
        if (!rst) begin
            case (state)
                EXECUTER, EXECUTEI: alu_op = ALUOP_FUNCT;
                BEQ:                alu_op = ALUOP_SUB;
                default:            alu_op = ALUOP_ADD;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        InstrDone  = 1'b0;
        Trap       = 1'b0;

        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = funct_illegal ? TRAP : EXECUTER;
                    OP_IALU:      next_state = funct_illegal ? TRAP : EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = (funct3 == 3'b000) ? BEQ : TRAP;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_SW) ? IMM_S : IMM_I;
                next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    InstrDone  = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                next_state = ALUWB;
            end
            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            // PC takes the target already in ALUOut while the ALU forms the link value.
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ImmSrc     = IMM_J;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = Zero;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                Trap       = 1'b1;
                next_state = TRAP;
            end
            default: next_state = TRAP;
        endcase

        // State is already FETCH under reset; blank the FETCH request until release.
        if (rst) begin
            MemReq    = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = '0;
            ALUSrcA   = '0;
            ALUSrcB   = '0;
            ImmSrc    = '0;
            InstrDone = 1'b0;
            Trap      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected control
// schedules are built from the instruction-level rules and compared cycle by cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_bit5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       InstrDone, Trap;

    int vectors = 0;
    int miscompares = 0;

    logic [18:0] exp_q[$];
    logic        rdy_q[$];
    logic        zero_q[$];
    logic [18:0] obs;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7_bit5 (funct7_bit5),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .MemReq      (MemReq),
        .MemWrite    (MemWrite),
        .AdrSrc      (AdrSrc),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUControl  (ALUControl),
        .ImmSrc      (ImmSrc),
        .InstrDone   (InstrDone),
        .Trap        (Trap)
    );

    always #5 clk = ~clk;

    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Trap};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] ov(input logic req, input logic wr, input logic adr,
                                       input logic irw, input logic pcw, input logic rgw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] imm, input logic done,
                                       input logic trap);
        return {req, wr, adr, irw, pcw, rgw, rs, sa, sb, alu, imm, done, trap};
    endfunction

    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic op5, input logic b5);
        case (f3)
            3'b000:  return (op5 && b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit legal_ref(input logic [31:0] ir);
        logic [6:0] o;
        logic [2:0] f;
        o = ir[6:0];
        f = ir[14:12];
        case (o)
            7'd3, 7'd35, 7'd111: return 1'b1;
            7'd51, 7'd19:        return (f == 3'b000 || f == 3'b010 || f == 3'b110 || f == 3'b111);
            7'd99:               return (f == 3'b000);
            default:             return 1'b0;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [18:0] v);
        rdy_q.push_back(rdy);
        zero_q.push_back(z);
        exp_q.push_back(v);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle control schedule for one instruction, starting in FETCH.
    task automatic build(input logic [31:0] ir, input logic z, input int fw, input int mw);
        logic [6:0] o;
        logic [2:0] f3;
        logic       b5;
        o  = ir[6:0];
        f3 = ir[14:12];
        b5 = ir[30];
        op = o;
        funct3 = f3;
        funct7_bit5 = b5;
        for (int i = 0; i < fw; i++)
            push(1'b0, rnd(), ov(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0,0));
        push(1'b1, rnd(), ov(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0,0));
        push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000,
                              (o == 7'd111) ? 2'b11 : 2'b10, 0,0));
        if (!legal_ref(ir)) begin
            for (int i = 0; i < 4; i++)
                push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0,1));
            return;
        end
        case (o)
            7'd3: begin
                push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0,0));
                for (int i = 0; i < mw; i++)
                    push(1'b0, rnd(), ov(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0,0));
                push(1'b1, rnd(), ov(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0,0));
                push(rnd(), rnd(), ov(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1,0));
            end
            7'd35: begin
                push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0,0));
                for (int i = 0; i < mw; i++)
                    push(1'b0, rnd(), ov(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0,0));
                push(1'b1, rnd(), ov(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1,0));
            end
            7'd51: begin
                push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, alu_ref(f3, 1'b1, b5), 2'b00, 0,0));
                push(rnd(), rnd(), ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1,0));
            end
            7'd19: begin
                push(rnd(), rnd(), ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, alu_ref(f3, 1'b0, b5), 2'b00, 0,0));
                push(rnd(), rnd(), ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1,0));
            end
            7'd111: begin
                push(rnd(), rnd(), ov(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0,0));
                push(rnd(), rnd(), ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1,0));
            end
            default: begin
                push(rnd(), z, ov(0,0,0,0,z,0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1,0));
            end
        endcase
    endtask

    // Plays the first n scheduled cycles (all if n < 0); starts and ends just after a negedge.
    task automatic play(input string tag, input int n);
        int lim;
        lim = (n < 0 || n > exp_q.size()) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready = rdy_q[i];
            Zero      = zero_q[i];
            #1;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: outputs got %b required %b", tag, i, obs, exp_q[i]);
            end
            @(negedge clk);
        end
        exp_q.delete();
        rdy_q.delete();
        zero_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        mem_ready = 1'b1;
        Zero = 1'b1;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL %s reset_outputs: got %b required %b", tag, obs, 19'd0);
        end
        @(negedge clk);
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL %s reset_held: got %b required %b", tag, obs, 19'd0);
        end
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset("reset");
        build(32'hFFC4A303, 1'b0, 1, 0);
        play("reset_first_fetch", -1);
    endtask

    task automatic test_lw();
        build(32'hFFC4A303, 1'b0, 0, 0);
        play("lw", -1);
    endtask

    task automatic test_sw();
        build(32'h0064A423, 1'b0, 0, 2);
        play("sw_wait2", -1);
    endtask

    task automatic test_beq();
        build(32'hFE420AE3, 1'b1, 0, 0);
        play("beq_taken", -1);
        build(32'hFE420AE3, 1'b0, 0, 0);
        play("beq_not_taken", -1);
    endtask

    task automatic test_rtype();
        build(32'h40000033, 1'b0, 0, 0);
        play("sub", -1);
        build(32'h00006033, 1'b0, 0, 0);
        play("or", -1);
        build(32'h00002033, 1'b0, 0, 0);
        play("slt", -1);
        build(32'h40000013, 1'b0, 0, 0);
        play("addi_b30", -1);
        build(32'h0000F013, 1'b0, 0, 0);
        play("andi", -1);
    endtask

    task automatic test_jal();
        build(32'h0080006F, 1'b0, 0, 0);
        play("jal", -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir;
        logic [2:0]  fsel[4];
        fsel[0] = 3'b000; fsel[1] = 3'b010; fsel[2] = 3'b110; fsel[3] = 3'b111;
        for (int k = 0; k < 60; k++) begin
            ir = $urandom();
            case ($urandom_range(0, 5))
                0: begin ir[6:0] = 7'd3;   ir[14:12] = 3'b010; end
                1: begin ir[6:0] = 7'd35;  ir[14:12] = 3'b010; end
                2: begin ir[6:0] = 7'd51;  ir[14:12] = fsel[$urandom_range(0, 3)]; end
                3: begin ir[6:0] = 7'd19;  ir[14:12] = fsel[$urandom_range(0, 3)]; end
                4: begin ir[6:0] = 7'd99;  ir[14:12] = 3'b000; end
                default: ir[6:0] = 7'd111;
            endcase
            build(ir, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
            play("random", -1);
        end
    endtask

    task automatic test_illegal();
        do_reset("illegal_r");
        build(32'h00001033, 1'b0, 0, 0);
        play("illegal_r_funct3", -1);
        do_reset("illegal_i");
        build(32'h00005013, 1'b0, 0, 0);
        play("illegal_i_funct3", -1);
        do_reset("illegal_beq");
        build(32'h00001063, 1'b0, 0, 0);
        play("illegal_beq_funct3", -1);
    endtask

    task automatic test_trap_reset();
        logic [18:0] fetch_wait;
        fetch_wait = ov(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0,0);
        do_reset("trap");
        build(32'h0000007F, 1'b0, 1, 0);
        play("trap_opcode", -1);
        do_reset("trap_clear");
        build(32'hFFC4A303, 1'b0, 0, 3);
        play("lw_to_memread", 4);
        mem_ready = 1'b1;
        Zero = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL async_rst_memread: got %b required %b", obs, 19'd0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL rst_over_edge: got %b required %b", obs, 19'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (obs !== fetch_wait) begin
            miscompares++;
            $display("FAIL post_rst_fetch: got %b required %b", obs, fetch_wait);
        end
        @(negedge clk);
        build(32'hFFC4A303, 1'b0, 0, 1);
        play("lw_after_abort", -1);
        build(32'h0080006F, 1'b0, 0, 0);
        play("jal_after_abort", -1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_rtype();
        test_jal();
        test_back_to_back();
        test_illegal();
        test_trap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the multicycle RV32I datapath: shared instruction/data memory, instruction register, old-PC/ALUOut/Data registers, and the existing ALU and Extend units. Each instruction is decoded from IR fields and steps through fetch, decode, execute, memory and writeback states. The controller drives every mux select and write strobe, and handshakes with the unified memory port. It replaces the single-cycle decoder in the multicycle CPU top.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_bit5  in  1  IR[30].
- Zero  in  1  ALU zero flag, combinational in the current cycle.
- mem_ready  in  1  memory accepted/completed the access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write qualifier, valid with MemReq.
- AdrSrc  out  1  0 = PC, 1 = ALUOut drives the memory address.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register-file write enable.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction.
- Trap  out  1  illegal instruction detected; held until reset.

## Operation
- Supported opcodes: lw 3, sw 35, R-type 51, I-ALU 19, beq 99 (funct3 must be 000), jal 111. Any other opcode goes to TRAP.
- Any unsupported funct3 for R-type or I-ALU goes to TRAP from DECODE.
- Unlisted outputs are 0 in every state. "Don't care" selects are also driven 0.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. Holds while mem_ready=0. In the cycle mem_ready=1, IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (ALUOut receives the branch target). Next state:
  - lw/sw: MEMADR.
  - R-type: EXECUTER.
  - I-ALU: EXECUTEI.
  - jal: JAL.
  - beq: BEQ.
  - illegal: TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for lw, 01 for sw. Next: lw to MEMREAD, sw to MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next: FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, held for every wait cycle. On mem_ready=1, InstrDone=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decoder result. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALU decoder result. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ImmSrc=11, ResultSrc=00, PCWrite=1 (PC takes the target; ALUOut takes OldPC+4). Next: ALUWB.
  - DECODE must use ImmSrc=11 when op=111 so the J-type target is computed.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, InstrDone=1. Next: FETCH.
- TRAP: Trap=1, all strobes 0. Absorbing state; only rst exits.
- ALU decoder, with ALUOp 00 = add, 01 = sub, 10 = by funct:
  - funct3 000: sub when op[5] & funct7_bit5, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Other funct3 values are illegal.

## Timing
- rst asserted (asynchronous): state becomes FETCH immediately, and every output is forced to 0 while rst is high, including MemReq and Trap.
- The first MemReq appears in the first cycle after rst deasserts.
- Outputs are a combinational function of state plus mem_ready/Zero/IR fields. There are no registered outputs apart from the state register.
- Minimum cycle counts with zero wait states: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored outside the memory states.
- No strobe other than MemReq/MemWrite/AdrSrc is asserted during a wait cycle.
- Reset mid-instruction aborts the instruction. There is no partial PCWrite or RegWrite after the edge on which rst rises.

## Structure
- cpu_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP;
  - opcode constants;
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module alu_decoder: combinational inputs ALUOp, funct3, op[5], funct7_bit5; outputs ALUControl and illegal.
- The top contains the state register (async reset) and the next-state/output logic.

## Test plan
- lw (0xFFC4A303) with mem_ready tied 1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. RegWrite=1 with ResultSrc=01 only in cycle 5, and InstrDone pulses once.
- sw (0x0064A423) with mem_ready low for 2 cycles in MEMWRITE: MemReq=MemWrite=AdrSrc=1 for 3 cycles, InstrDone only on the ready cycle, total 6 cycles.
- beq (0xFE420AE3) with Zero=1: PCWrite=1 in cycle 3. Repeat with Zero=0: PCWrite=0 and the next cycle is FETCH.
- R-type sequence sub (funct7_bit5=1, funct3 000), or (110), slt (010): ALUControl 001/011/101 in EXECUTER. addi with IR[30]=1 gives 000.
- jal (0x0080006F): DECODE and JAL show ImmSrc=11, PCWrite=1 in the JAL state, RegWrite in ALUWB, 4 cycles.
- Opcode 0x7F, then rst pulsed mid-MEMREAD: Trap=1 from the cycle after DECODE, held with all strobes 0. Asynchronous rst clears Trap and state, and after release MemReq=1 with AdrSrc=0.
